// File: rtl/vga_pixel_engine.sv
// VGA timing generator that fetches BPP-bit pixel indices from frame memory and maps them through a 12-bit palette.
// Sync, blanking and colour all leave through one RD_LATENCY+1 tick pipeline, so they stay aligned.
module vga_pixel_engine #(
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int CLK_DIV    = 2,
  parameter int BPP        = 2,
  parameter int ADDR_W     = 19,
  parameter int RD_LATENCY = 1,
  parameter bit SYNC_POL   = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pal_we,
  input  logic [BPP-1:0]    pal_addr,
  input  logic [11:0]       pal_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [BPP-1:0]    rd_data,
  output logic              hSync,
  output logic              vSync,
  output logic [11:0]       component,
  output logic              frame_start
);
  localparam int HT    = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int VT    = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HW    = $clog2(HT + 1);
  localparam int VW    = $clog2(VT + 1);
  localparam int DW    = $clog2(CLK_DIV + 1);
  localparam int DLY   = RD_LATENCY + 1;
  localparam int PAL_N = 1 << BPP;

  localparam logic [DW-1:0]     DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0]     H_LAST    = HW'(HT - 1);
  localparam logic [HW-1:0]     H_SYNC_E  = HW'(H_SYNC);
  localparam logic [HW-1:0]     H_ACT_BEG = HW'(H_SYNC + H_BACK);
  localparam logic [HW-1:0]     H_ACT_END = HW'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [VW-1:0]     V_LAST    = VW'(VT - 1);
  localparam logic [VW-1:0]     V_SYNC_E  = VW'(V_SYNC);
  localparam logic [VW-1:0]     V_ACT_BEG = VW'(V_SYNC + V_BACK);
  localparam logic [VW-1:0]     V_ACT_END = VW'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  logic [DW-1:0]     div_cnt;
  logic              tick;
  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic [ADDR_W-1:0] addr_cnt;
  logic              h_wrap, v_wrap, active;
  logic              hs_raw, vs_raw, fs_raw;
  logic [DLY-1:0]    act_dly, hs_dly, vs_dly, fs_dly;
  logic [BPP-1:0]    pix_idx;
  logic [11:0]       palette [PAL_N];

  assign tick   = (div_cnt == DIV_LAST);
  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);
  assign active = (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END) &&
                  (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
  assign hs_raw = (h_cnt < H_SYNC_E);
  assign vs_raw = (v_cnt < V_SYNC_E);
  assign fs_raw = (h_cnt == H_ACT_BEG) && (v_cnt == V_ACT_BEG);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt  <= '0;
      h_cnt    <= '0;
      v_cnt    <= '0;
      addr_cnt <= '0;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      rd_en   <= tick && active;
      if (tick) begin
        h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
        if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
        // frame end wins over the per-request increment so every frame restarts at address 0
        if (h_wrap && v_wrap)
          addr_cnt <= '0;
        else if (active)
          addr_cnt <= (addr_cnt == ADDR_LAST) ? '0 : addr_cnt + 1'b1;
        if (active) rd_addr <= addr_cnt;
      end
    end
  end

  // Delay line resets to "not in sync", so nothing pulses until real timing reaches the outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      act_dly     <= '0;
      hs_dly      <= '0;
      vs_dly      <= '0;
      fs_dly      <= '0;
      pix_idx     <= '0;
      component   <= 12'h000;
      hSync       <= ~SYNC_POL;
      vSync       <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && fs_dly[DLY-1];
      if (tick) begin
        act_dly   <= {act_dly[DLY-2:0], active};
        hs_dly    <= {hs_dly[DLY-2:0], hs_raw};
        vs_dly    <= {vs_dly[DLY-2:0], vs_raw};
        fs_dly    <= {fs_dly[DLY-2:0], fs_raw};
        pix_idx   <= rd_data;
        component <= act_dly[DLY-1] ? palette[pix_idx] : 12'h000;
        hSync     <= hs_dly[DLY-1] ? SYNC_POL : ~SYNC_POL;
        vSync     <= vs_dly[DLY-1] ? SYNC_POL : ~SYNC_POL;
      end
    end
  end

  // Writes land on the edge; a lookup on that same edge still sees the previous colour.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PAL_N; i++)
        palette[i] <= (i == 0) ? 12'h000 : 12'hFFF;
    end else if (pal_we) begin
      palette[pal_addr] <= pal_data;
    end
  end
endmodule

// File: tb/tb_vga_pixel_engine.sv
// Directed bench: small-timing instance at CLK_DIV=1 and default-horizontal instance at CLK_DIV=2.
module tb_vga_pixel_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // instance A: H 2/1/4/1, V 1/1/3/1, CLK_DIV=1
  logic        rst_n_a, pal_we_a, rd_en_a, hs_a, vs_a, fs_a;
  logic [1:0]  pal_addr_a, rd_data_a, idx_a;
  logic [11:0] pal_data_a, comp_a;
  logic [7:0]  rd_addr_a;
  assign rd_data_a = idx_a;

  vga_pixel_engine #(
    .H_SYNC(2), .H_BACK(1), .H_ACTIVE(4), .H_FRONT(1),
    .V_SYNC(1), .V_BACK(1), .V_ACTIVE(3), .V_FRONT(1),
    .CLK_DIV(1), .BPP(2), .ADDR_W(8), .RD_LATENCY(1), .SYNC_POL(1'b0)
  ) dut_a (
    .clock(clk), .reset(rst_n_a), .pal_we(pal_we_a), .pal_addr(pal_addr_a),
    .pal_data(pal_data_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .hSync(hs_a), .vSync(vs_a), .component(comp_a), .frame_start(fs_a)
  );

  // instance B: default horizontal timing, V 1/1/2/1, CLK_DIV=2
  logic        rst_n_b, pal_we_b, rd_en_b, hs_b, vs_b, fs_b;
  logic [1:0]  pal_addr_b, rd_data_b;
  logic [11:0] pal_data_b, comp_b;
  logic [18:0] rd_addr_b;
  assign rd_data_b = rd_addr_b[1:0] ^ 2'b01;

  vga_pixel_engine #(
    .H_SYNC(96), .H_BACK(48), .H_ACTIVE(640), .H_FRONT(16),
    .V_SYNC(1), .V_BACK(1), .V_ACTIVE(2), .V_FRONT(1),
    .CLK_DIV(2), .BPP(2), .ADDR_W(19), .RD_LATENCY(1), .SYNC_POL(1'b0)
  ) dut_b (
    .clock(clk), .reset(rst_n_b), .pal_we(pal_we_b), .pal_addr(pal_addr_b),
    .pal_data(pal_data_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .hSync(hs_b), .vSync(vs_b), .component(comp_b), .frame_start(fs_b)
  );

  initial begin
    int hs_low, hs_fall, hs_first, vs_low, vs_fall, vs_first;
    int rd_n, rd_n48, rd_first, nz, nz_first, nz_bad, fs_n, fs_first;
    int f00_n, bad3, nz5;
    int hf1, hf2, hr1, vf1, vf2, vr1, b_rd, b_rd_first, b_consec, b_fs_n, b_fs1, b_fs2;
    logic hs_p, vs_p, rd_p;
    logic [11:0] comp_p;
    logic [18:0] b_first_addr;

    rst_n_a = 1'b0; rst_n_b = 1'b0;
    pal_we_a = 1'b0; pal_addr_a = '0; pal_data_a = '0; idx_a = 2'd1;
    pal_we_b = 1'b0; pal_addr_b = '0; pal_data_b = '0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_val("rst_comp", 32'(comp_a), 0);
    check_val("rst_hsync", 32'(hs_a), 1);
    check_val("rst_vsync", 32'(vs_a), 1);
    check_val("rst_rden", 32'(rd_en_a), 0);
    check_val("rst_rdaddr", 32'(rd_addr_a), 0);
    check_val("rst_fs", 32'(fs_a), 0);
    check_val("rst_b_hsync", 32'(hs_b), 1);
    check_val("rst_b_comp", 32'(comp_b), 0);

    // ---------------- instance A, k = clock edges since release ----------------
    hs_low = 0; hs_fall = 0; hs_first = 0; vs_low = 0; vs_fall = 0; vs_first = 0;
    rd_n = 0; rd_n48 = 0; rd_first = 0; nz = 0; nz_first = 0; nz_bad = 0;
    fs_n = 0; fs_first = 0; f00_n = 0; bad3 = 0; nz5 = 0;
    hs_p = 1'b1; vs_p = 1'b1;
    rst_n_a = 1'b1;
    for (int k = 1; k <= 240; k++) begin
      @(negedge clk);
      if (k <= 96) begin
        if (!hs_a) begin hs_low++; if (hs_first == 0) hs_first = k; end
        if (!hs_a && hs_p) hs_fall++;
        if (!vs_a) begin vs_low++; if (vs_first == 0) vs_first = k; end
        if (!vs_a && vs_p) vs_fall++;
        if (fs_a) begin fs_n++; if (fs_first == 0) fs_first = k; end
        if (comp_a != 12'h000) begin
          nz++;
          if (nz_first == 0) nz_first = k;
          if (comp_a != 12'hFFF) nz_bad++;
        end
        if (rd_en_a) begin
          check_val("a_rd_addr_seq", 32'(rd_addr_a), rd_n % 12);
          rd_n++;
          if (k <= 48) rd_n48++;
          if (rd_first == 0) rd_first = k;
        end
      end else if (k <= 144) begin
        if (comp_a == 12'hF00) f00_n++;
        else if (comp_a != 12'h000) bad3++;
      end else if (k == 166) begin
        check_val("a_collide_old", 32'(comp_a), 32'h0FFF);
      end else if (k == 167) begin
        check_val("a_collide_new", 32'(comp_a), 32'h00F0);
      end else if (k > 192) begin
        if (comp_a != 12'h000) nz5++;
        if (k == 214) check_val("a_frame5_fs", 32'(fs_a), 1);
      end
      hs_p = hs_a; vs_p = vs_a;
      // stimulus for the next edge
      pal_we_a = 1'b0;
      if (k == 96)  begin idx_a = 2'd2; pal_we_a = 1'b1; pal_addr_a = 2'd2; pal_data_a = 12'hF00; end
      if (k == 144) idx_a = 2'd1;
      if (k == 165) begin pal_we_a = 1'b1; pal_addr_a = 2'd1; pal_data_a = 12'h0F0; end
      if (k == 192) idx_a = 2'd0;
    end
    check_val("a_hs_low_clks", hs_low, 24);
    check_val("a_hs_pulses", hs_fall, 12);
    check_val("a_hs_first", hs_first, 3);
    check_val("a_vs_low_clks", vs_low, 16);
    check_val("a_vs_pulses", vs_fall, 2);
    check_val("a_vs_first", vs_first, 3);
    check_val("a_rd_per_frame", rd_n48, 12);
    check_val("a_rd_two_frames", rd_n, 24);
    check_val("a_rd_first", rd_first, 20);
    check_val("a_colour_first", nz_first, 22);
    check_val("a_colour_count", nz, 24);
    check_val("a_colour_not_fff", nz_bad, 0);
    check_val("a_fs_count", fs_n, 2);
    check_val("a_fs_first", fs_first, 22);
    check_val("a_pal_f00_count", f00_n, 12);
    check_val("a_pal_f00_other", bad3, 0);
    check_val("a_entry0_black", nz5, 0);

    // ---------------- instance B: run into active line, reset mid-line ----------------
    rst_n_b = 1'b1;
    repeat (3602) @(negedge clk);
    check_val("b_pre_comp", 32'(comp_b), 32'h0FFF);
    check_val("b_pre_rden", 32'(rd_en_b), 1);
    #1 rst_n_b = 1'b0;
    #1;
    check_val("b_midrst_comp", 32'(comp_b), 0);
    check_val("b_midrst_rden", 32'(rd_en_b), 0);
    check_val("b_midrst_rdaddr", 32'(rd_addr_b), 0);
    check_val("b_midrst_hsync", 32'(hs_b), 1);
    check_val("b_midrst_vsync", 32'(vs_b), 1);
    repeat (5) @(negedge clk);
    rst_n_b = 1'b1;

    hf1 = 0; hf2 = 0; hr1 = 0; vf1 = 0; vf2 = 0; vr1 = 0;
    b_rd = 0; b_rd_first = 0; b_consec = 0; b_fs_n = 0; b_fs1 = 0; b_fs2 = 0;
    b_first_addr = '1;
    hs_p = 1'b1; vs_p = 1'b1; rd_p = 1'b0; comp_p = 12'h000;
    for (int c = 1; c <= 12000; c++) begin
      @(negedge clk);
      if (hs_p && !hs_b) begin if (hf1 == 0) hf1 = c; else if (hf2 == 0) hf2 = c; end
      if (!hs_p && hs_b && hr1 == 0) hr1 = c;
      if (vs_p && !vs_b) begin if (vf1 == 0) vf1 = c; else if (vf2 == 0) vf2 = c; end
      if (!vs_p && vs_b && vr1 == 0) vr1 = c;
      if (rd_en_b) begin
        if (c <= 8000) b_rd++;
        if (b_rd_first == 0) begin b_rd_first = c; b_first_addr = rd_addr_b; end
        if (rd_p) b_consec++;
      end
      if (fs_b) begin
        b_fs_n++;
        if (b_fs1 == 0) b_fs1 = c; else if (b_fs2 == 0) b_fs2 = c;
        check_val("b_fs_pixel0_colour", 32'(comp_b), 32'h0FFF);
        check_val("b_fs_prev_blank", 32'(comp_p), 0);
      end
      hs_p = hs_b; vs_p = vs_b; rd_p = rd_en_b; comp_p = comp_b;
    end
    check_val("b_hs_first_fall", hf1, 6);
    check_val("b_hs_width", hr1 - hf1, 192);
    check_val("b_hs_period", hf2 - hf1, 1600);
    check_val("b_vs_first_fall", vf1, 6);
    check_val("b_vs_width", vr1 - vf1, 1600);
    check_val("b_frame_period", vf2 - vf1, 8000);
    check_val("b_rd_first", b_rd_first, 3490);
    check_val("b_rd_first_addr", 32'(b_first_addr), 0);
    check_val("b_rd_per_frame", b_rd, 1280);
    check_val("b_rd_consecutive", b_consec, 0);
    check_val("b_fs_count", b_fs_n, 2);
    check_val("b_fs_first", b_fs1, 3494);
    check_val("b_fs_period", b_fs2 - b_fs1, 8000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
